// File: rtl/gate4_serial_pkg.sv
// Shared types for the bit-serial logic unit: op codes and FSM states.
package gate4_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_OR  = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

endpackage

// File: rtl/gate4_serial_if.sv
// Request/response handshake bundle between a producer and gate4_serial.
interface gate4_serial_if
  import gate4_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zero
  );

endinterface

// File: rtl/gate4_serial_gate1_slice.sv
// Single-bit combinational gate shared by every bit position of the serial unit.
module gate1_slice
  import gate4_pkg::*;
(
  input  op_t  op,
  input  logic a,
  input  logic b,
  output logic y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate4_serial.sv
// Bit-serial NOT/OR/AND/XOR unit: one result bit per clock, LSB first,
// through a single gate1_slice, with valid/ready on both sides.
module gate4_serial
  import gate4_pkg::*;
#(
  parameter int WIDTH = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  gate4_serial_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  op_t              op_q,     op_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] out_q,    out_d;
  logic             zero_q,   zero_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             slice_y;
  logic [WIDTH-1:0] res_next;

  gate1_slice u_slice (
    .op (op_q),
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .y  (slice_y)
  );

  // Fresh bit enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
  assign res_next = {slice_y, res_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    out_d    = out_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        res_sr_d = res_next;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        if (cnt_q == CNT_LAST) begin
          out_d   = res_next;
          zero_d  = (res_next == '0);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOT;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake flags depend on the state register alone.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_gate4_serial.sv
// Directed plus randomized bench for gate4_serial against a word-level gate model.
module tb_gate4_serial;
  import gate4_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [W-1:0] prev_out;
  logic         prev_zero;

  gate4_serial_if #(.WIDTH(W)) bus ();

  gate4_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_gate(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0:       return ~a;
      1:       return a | b;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge back in IDLE.
  task automatic txn(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int stall, input bit ones_mid, input bit pulse_in);
    logic [W-1:0] exp;
    logic         z;
    int           waited;
    exp    = ref_gate(op, a, b);
    z      = (exp == '0);
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op_t'(op[1:0]);
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int k = 0; k < W; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = ones_mid ? {W{1'b1}} : W'($urandom);
      bus.b        = ones_mid ? {W{1'b1}} : W'($urandom);
      bus.op       = op_t'($urandom_range(0, 3));
      check($sformatf("busy%0d", k),
            {25'd0, bus.in_ready, bus.out_valid, bus.out, bus.zero},
            {25'd0, 1'b0, 1'b0, prev_out, prev_zero});
      @(negedge clk);
    end
    bus.in_valid  = pulse_in;
    bus.out_ready = (stall == 0);
    check("done", {25'd0, bus.out_valid, bus.in_ready, bus.out, bus.zero},
          {25'd0, 1'b1, 1'b0, exp, z});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d", s),
            {25'd0, bus.out_valid, bus.in_ready, bus.out, bus.zero},
            {25'd0, 1'b1, 1'b0, exp, z});
      bus.in_valid = pulse_in ? ~bus.in_valid : 1'b0;
      if (s == stall - 1) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_after", {25'd0, bus.in_ready, bus.out_valid, bus.out, bus.zero},
          {25'd0, 1'b1, 1'b0, exp, z});
    prev_out  = exp;
    prev_zero = z;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    prev_out      = '0;
    prev_zero     = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_NOT;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.op        = op_t'($urandom_range(0, 3));
      #1;
      check("reset_hold", {25'd0, bus.in_ready, bus.out_valid, bus.out, bus.zero},
            {25'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);

    txn(3, 4'b1100, 4'b1010, 0, 1'b0, 1'b0);
    txn(0, 4'b1111, 4'b1010, 0, 1'b0, 1'b0);
    txn(0, 4'b1111, 4'b0101, 1, 1'b0, 1'b0);
    txn(2, 4'b1011, 4'b0110, 5, 1'b0, 1'b1);
    txn(1, 4'b1001, 4'b0100, 0, 1'b0, 1'b0);
    txn(1, 4'b0101, 4'b0010, 0, 1'b1, 1'b0);

    // Abort a transaction two cycles into BUSY.
    bus.in_valid = 1'b1;
    bus.op       = OP_XOR;
    bus.a        = 4'b1111;
    bus.b        = 4'b0000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_reset", {25'd0, bus.in_ready, bus.out_valid, bus.out, bus.zero},
          {25'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
    @(negedge clk);
    rst_n     = 1'b1;
    prev_out  = '0;
    prev_zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_quiet", {25'd0, bus.in_ready, bus.out_valid, bus.out, bus.zero},
            {25'd0, 1'b1, 1'b0, 4'b0000, 1'b0});
    end

    txn(3, 4'b0011, 4'b0101, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 3)), W'($urandom), W'($urandom),
          int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
